avg_window_3x3: RTL and testbench

Consumer end of the 3-row line buffer in the average filter path. Takes three vertically aligned pixel taps per beat, builds a 3x3 window, and emits the window mean for every interior pixel of the frame. Also emits frame-end and busy status. Sits between the line buffer outputs and the result writer.

---
 rtl/avg_window_3x3_pkg.sv | 15 +
 rtl/avg_window_3x3_sum9.sv | 72 +++++++
 rtl/avg_window_3x3.sv | 100 ++++++++++
 tb/tb_avg_window_3x3.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_window_3x3_pkg.sv
// Shared constants and FSM encoding for the 3x3 average filter consumer.
// The optional AVG_ROUND_EN macro selects round-to-nearest in avg_sum9.
package avg_pkg;

  localparam int unsigned DIV9_MUL   = 7282;
  localparam int unsigned DIV9_SHIFT = 16;
  localparam int unsigned ROUND_BIAS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/avg_window_3x3_sum9.sv
// Stages 2-4 of the 3x3 mean: row sums, total, multiply-shift divide by 9.
// Build option: define AVG_ROUND_EN to round to nearest instead of floor.
module avg_sum9
  import avg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic [8:0][WIDTH-1:0] i_win,
  input  logic                  i_valid,
  input  logic                  i_eof,
  output logic [WIDTH-1:0]      o_mean,
  output logic                  o_valid,
  output logic                  o_eof,
  output logic                  o_busy
);

  localparam int unsigned RW = WIDTH + 2;
  localparam int unsigned TW = WIDTH + 4;
  localparam int unsigned PW = WIDTH + 16;

  logic [RW-1:0]    r_row_sum [3];
  logic [TW-1:0]    r_total;
  logic [WIDTH-1:0] r_mean;
  logic             r_vld2, r_vld3, r_vld4;
  logic             r_eof2, r_eof3, r_eof4;
  logic [TW-1:0]    w_biased;
  logic [PW-1:0]    w_prod;

  always_comb begin
`ifdef AVG_ROUND_EN
    w_biased = r_total + TW'(ROUND_BIAS);
`else
    w_biased = r_total;
`endif
    w_prod = PW'(w_biased) * PW'(DIV9_MUL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < 3; r++) r_row_sum[r] <= '0;
      r_total <= '0;
      r_mean  <= '0;
      r_vld2  <= 1'b0;
      r_vld3  <= 1'b0;
      r_vld4  <= 1'b0;
      r_eof2  <= 1'b0;
      r_eof3  <= 1'b0;
      r_eof4  <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < 3; r++)
        r_row_sum[r] <= RW'(i_win[r*3]) + RW'(i_win[r*3+1]) + RW'(i_win[r*3+2]);
      r_total <= TW'(r_row_sum[0]) + TW'(r_row_sum[1]) + TW'(r_row_sum[2]);
      if (r_vld3) r_mean <= w_prod[DIV9_SHIFT +: WIDTH];
      // A restart drops every in-flight result so the aborted frame emits nothing more.
      r_vld2 <= i_valid & ~i_clear;
      r_eof2 <= i_valid & i_eof & ~i_clear;
      r_vld3 <= r_vld2 & ~i_clear;
      r_eof3 <= r_eof2 & ~i_clear;
      r_vld4 <= r_vld3 & ~i_clear;
      r_eof4 <= r_eof3 & ~i_clear;
    end
  end

  assign o_mean  = r_mean;
  assign o_valid = r_vld4;
  assign o_eof   = r_eof4;
  assign o_busy  = r_vld2 | r_vld3 | r_vld4;

endmodule

// File: rtl/avg_window_3x3.sv
// 3x3 window builder and frame tracker feeding avg_sum9; emits interior-pixel means.
// Build option AVG_ROUND_EN (see avg_sum9) selects rounding; latency unchanged.
module avg_window_3x3
  import avg_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PIC_WIDTH  = 320,
  parameter int unsigned PIC_HEIGHT = 240
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             sof,
  input  logic [WIDTH-1:0] tap_top,
  input  logic [WIDTH-1:0] tap_mid,
  input  logic [WIDTH-1:0] tap_bot,
  output logic [WIDTH-1:0] dout,
  output logic             valid_out,
  output logic             eof_out,
  output logic             busy
);

  localparam logic [8:0] LAST_COL = 9'(PIC_WIDTH - 1);
  localparam logic [8:0] LAST_ROW = 9'(PIC_HEIGHT - 1);

  state_t                r_state;
  logic [8:0]            r_col, r_row;
  logic [8:0][WIDTH-1:0] r_win;
  logic                  r_win_vld, r_win_eof;

  logic       w_start, w_accept, w_emit, w_last;
  logic [8:0] w_col, w_row;
  logic       w_sum_busy, w_pipe_busy;

  // r_col/r_row point at the next expected beat; a sof beat is always (0,0).
  always_comb begin
    w_start  = valid_in & sof;
    w_accept = valid_in & (sof | (r_state == RUN));
    w_col    = sof ? '0 : r_col;
    w_row    = sof ? '0 : r_row;
    w_emit   = w_accept & (w_row >= 9'd2) & (w_col >= 9'd2);
    w_last   = w_accept & (w_row == LAST_ROW) & (w_col == LAST_COL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_win     <= '0;
      r_win_vld <= 1'b0;
      r_win_eof <= 1'b0;
    end else begin
      r_win_vld <= w_emit;
      r_win_eof <= w_last;
      if (w_accept) begin
        for (int unsigned r = 0; r < 3; r++) begin
          r_win[r*3]   <= r_win[r*3+1];
          r_win[r*3+1] <= r_win[r*3+2];
        end
        r_win[2] <= tap_top;
        r_win[5] <= tap_mid;
        r_win[8] <= tap_bot;
        if (w_col == LAST_COL) begin
          r_col <= '0;
          r_row <= (w_row == LAST_ROW) ? '0 : w_row + 9'd1;
        end else begin
          r_col <= w_col + 9'd1;
          r_row <= w_row;
        end
      end
      if (w_start) begin
        r_state <= RUN;
      end else begin
        case (r_state)
          RUN:     if (w_last) r_state <= DONE;
          DONE:    if (!w_pipe_busy) r_state <= IDLE;
          default: r_state <= r_state;
        endcase
      end
    end
  end

  avg_sum9 #(.WIDTH(WIDTH)) u_sum9 (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start),
    .i_win   (r_win),
    .i_valid (r_win_vld),
    .i_eof   (r_win_eof),
    .o_mean  (dout),
    .o_valid (valid_out),
    .o_eof   (eof_out),
    .o_busy  (w_sum_busy)
  );

  assign w_pipe_busy = r_win_vld | w_sum_busy;
  assign busy        = (r_state == RUN) | w_pipe_busy;

endmodule

// File: tb/tb_avg_window_3x3.sv
// Self-checking bench for avg_window_3x3 on a 5x4 frame: vector table plus scoreboard queue.
module tb_avg_window_3x3;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst, valid_in, sof;
  logic [7:0] tap_top, tap_mid, tap_bot, dout;
  logic       valid_out, eof_out, busy;

  always #5 clk = ~clk;

  avg_window_3x3 #(.WIDTH(8), .PIC_WIDTH(W), .PIC_HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sof       (sof),
    .tap_top   (tap_top),
    .tap_mid   (tap_mid),
    .tap_bot   (tap_bot),
    .dout      (dout),
    .valid_out (valid_out),
    .eof_out   (eof_out),
    .busy      (busy)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] val;
    logic       eof;
    longint     due;
  } exp_t;

  typedef struct {
    int kind;
    int flat;
    int gap;
    int abort_beats;
    int exp_n;
    int exp_first;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  int   out_vals[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  int   img[H][W];
  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int model_mean(input int sum);
`ifdef AVG_ROUND_EN
    return (sum + 4) / 9;
`else
    return sum / 9;
`endif
  endfunction

  function automatic int pix(input int kind, input int flat, input int x, input int y);
    case (kind)
      0:       return flat;
      1:       return x + 10 * y;
      2:       return (x == 2 && y == 2) ? 8 : 0;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  always @(negedge clk) begin
    if (valid_out) begin
      if (q.size() == 0) begin
        check("spurious_valid_out", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("dout", dout, mon_e.val);
        check("eof_out", eof_out, mon_e.eof);
        check("latency_cycle", cyc, mon_e.due);
        n_out++;
        out_vals.push_back(int'(dout));
      end
    end else if (eof_out) begin
      check("eof_without_valid", 1, 0);
    end
  end

  task automatic purge(input longint c);
    while (q.size() > 0 && q[q.size()-1].due > c) void'(q.pop_back());
  endtask

  task automatic drive_idle();
    @(posedge clk); #1;
    valid_in = 1'b0;
    sof      = 1'b0;
    tap_top  = 8'($urandom);
    tap_mid  = 8'($urandom);
    tap_bot  = 8'($urandom);
  endtask

  task automatic run_frame(input int kind, input int flat, input int gap, input int nbeats);
    int   x, y, sum, n_idle;
    exp_t e;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) img[yy][xx] = pix(kind, flat, xx, yy);
    for (int b = 0; b < nbeats; b++) begin
      x = b % W;
      y = b / W;
      if (b > 0) begin
        n_idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (n_idle) drive_idle();
      end
      @(posedge clk); #1;
      if (b == 1) check("busy_in_frame", busy, 1);
      if (b == 0) purge(cyc);
      valid_in = 1'b1;
      sof      = (b == 0);
      tap_bot  = 8'(img[y][x]);
      tap_mid  = (y >= 1) ? 8'(img[y-1][x]) : 8'($urandom);
      tap_top  = (y >= 2) ? 8'(img[y-2][x]) : 8'($urandom);
      if (y >= 2 && x >= 2) begin
        sum = 0;
        for (int r = y - 2; r <= y; r++)
          for (int c = x - 2; c <= x; c++) sum += img[r][c];
        e.val = 8'(model_mean(sum));
        e.eof = (x == W - 1) && (y == H - 1);
        e.due = cyc + 4;
        q.push_back(e);
      end
    end
    drive_idle();
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_queue_empty", q.size(), 0);
    @(posedge clk); #1;
    check("busy_low_after_frame", busy, 0);
  endtask

  task automatic check_frame(input int base, input int exp_n, input int exp_first);
    check("out_count", n_out - base, exp_n);
    if (exp_first >= 0) begin
      if (out_vals.size() > base) check("first_out", out_vals[base], exp_first);
      else check("first_out_missing", 0, 1);
    end
  endtask

  initial begin
    int base;
    rst      = 1'b1;
    valid_in = 1'b0;
    sof      = 1'b0;
    tap_top  = '0;
    tap_mid  = '0;
    tap_bot  = '0;

    vecs[0] = '{0, 100, 0, 0,  6, 100};
    vecs[1] = '{0, 255, 0, 0,  6, 255};
`ifdef AVG_ROUND_EN
    vecs[2] = '{2, 0,   0, 0,  6, 1};
`else
    vecs[2] = '{2, 0,   0, 0,  6, 0};
`endif
    vecs[3] = '{1, 0,   0, 0,  6, 11};
    vecs[4] = '{1, 0,   1, 0,  6, 11};
    vecs[5] = '{1, 0,   2, 11, 6, 11};
    vecs[6] = '{3, 0,   0, 14, 6, -1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_dout", dout, 0);
    check("reset_valid_out", valid_out, 0);
    check("reset_eof_out", eof_out, 0);
    check("reset_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      base = n_out;
      if (vecs[i].abort_beats > 0)
        run_frame(vecs[i].kind, vecs[i].flat, vecs[i].gap, vecs[i].abort_beats);
      run_frame(vecs[i].kind, vecs[i].flat, vecs[i].gap, W * H);
      drain();
      check_frame(base, vecs[i].exp_n, vecs[i].exp_first);
    end

    // Mid-frame reset with results in flight, then sof-less beats must be ignored.
    base = n_out;
    run_frame(0, 50, 0, 14);
    @(posedge clk); #1;
    rst      = 1'b1;
    valid_in = 1'b1;
    sof      = 1'b0;
    purge(cyc);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_reset_dout", dout, 0);
    check("mid_reset_valid_out", valid_out, 0);
    check("mid_reset_eof_out", eof_out, 0);
    check("mid_reset_busy", busy, 0);
    repeat (8) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      sof      = 1'b0;
      tap_top  = 8'($urandom);
      tap_mid  = 8'($urandom);
      tap_bot  = 8'($urandom);
    end
    drive_idle();
    repeat (6) @(posedge clk);
    #1;
    check("ignored_beats_busy", busy, 0);
    check("ignored_beats_outputs", n_out - base, 0);

    base = n_out;
    run_frame(0, 77, 0, W * H);
    drain();
    check_frame(base, 6, 77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1);
  end

endmodule
